// File: rtl/pipeline_stage_ctrl_pkg.sv
// Shared constants for the pipeline stage controller: state encoding and counter width.
package pipe_ctrl_pkg;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HAZ_STALL = 2'd1,
    MEM_WAIT  = 2'd2,
    REDIRECT  = 2'd3
  } state_t;
endpackage

// File: rtl/pipeline_stage_ctrl_if.sv
// Hazard requests in, pipeline-register enables/clears, valid bits and counters out.
interface pipeline_stage_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic             StallF, StallD, FlushE, PCSrcD, MemBusyM;
  // Debug preload of the stall counter (used to exercise saturation).
  logic             PreloadStall;
  logic [CNT_W-1:0] PreloadVal;

  logic             EnPC, EnIFID, EnIDEX, EnEXMEM, EnMEMWB;
  logic             ClrIFID, ClrIDEX;
  logic             ValidD, ValidE, ValidM, ValidW;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output StallF, StallD, FlushE, PCSrcD, MemBusyM, PreloadStall, PreloadVal,
    input  EnPC, EnIFID, EnIDEX, EnEXMEM, EnMEMWB, ClrIFID, ClrIDEX,
           ValidD, ValidE, ValidM, ValidW, State, StallCount, FlushCount
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcD, MemBusyM, PreloadStall, PreloadVal,
    output EnPC, EnIFID, EnIDEX, EnEXMEM, EnMEMWB, ClrIFID, ClrIDEX,
           ValidD, ValidE, ValidM, ValidW, State, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_stage_ctrl_sat_counter.sv
// Saturating up-counter; clear beats load beats increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (clear)                  count <= '0;
    else if (load)              count <= load_val;
    else if (inc && ~&count)    count <= count + 1'b1;
  end
endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Five-stage pipeline controller: turns hazard/memory events into register enables,
// bubble clears, per-stage valid tracking and stall/flush performance counters.
module pipeline_stage_ctrl
  import pipe_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  pipeline_stage_ctrl_if.slave bus
);
  state_t     state, state_nxt;
  logic       mem_hold, haz_stall, redirect;
  logic [3:0] vld_pipe;  // [0]=D .. [3]=W
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Event priority: memory hold > hazard stall > branch redirect.
  always_comb begin
    mem_hold  = bus.MemBusyM;
    haz_stall = !mem_hold && (bus.StallF || bus.StallD);
    redirect  = !mem_hold && !haz_stall && bus.PCSrcD;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    if (mem_hold)       state_nxt = MEM_WAIT;
    else if (haz_stall) state_nxt = HAZ_STALL;
    else if (redirect)  state_nxt = REDIRECT;
  end

  always_comb begin
    bus.EnPC    = 1'b1;
    bus.EnIFID  = 1'b1;
    bus.EnIDEX  = 1'b1;
    bus.EnEXMEM = 1'b1;
    bus.EnMEMWB = 1'b1;
    bus.ClrIFID = 1'b0;
    bus.ClrIDEX = 1'b0;
    if (reset) begin
      bus.ClrIFID = 1'b1;
      bus.ClrIDEX = 1'b1;
    end else if (mem_hold) begin
      bus.EnPC    = 1'b0;
      bus.EnIFID  = 1'b0;
      bus.EnIDEX  = 1'b0;
      bus.EnEXMEM = 1'b0;
      bus.EnMEMWB = 1'b0;
    end else begin
      bus.EnPC    = !haz_stall;
      bus.EnIFID  = !haz_stall;
      bus.ClrIFID = redirect;
      // FlushE alone still bubbles ID/EX even when nothing stalls.
      bus.ClrIDEX = haz_stall || bus.FlushE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (!mem_hold) begin
      vld_pipe[0] <= haz_stall ? vld_pipe[0] : !bus.ClrIFID;
      vld_pipe[1] <= bus.ClrIDEX ? 1'b0 : vld_pipe[0];
      vld_pipe[2] <= vld_pipe[1];
      vld_pipe[3] <= vld_pipe[2];
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk      (clk),
    .clear    (reset),
    .load     (bus.PreloadStall),
    .load_val (bus.PreloadVal),
    .inc      (mem_hold || haz_stall),
    .count    (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk      (clk),
    .clear    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (bus.ClrIFID || bus.ClrIDEX),
    .count    (flush_cnt)
  );

  assign bus.State      = state;
  assign bus.ValidD     = vld_pipe[0];
  assign bus.ValidE     = vld_pipe[1];
  assign bus.ValidM     = vld_pipe[2];
  assign bus.ValidW     = vld_pipe[3];
  assign bus.StallCount = stall_cnt;
  assign bus.FlushCount = flush_cnt;
endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Directed + random bench for pipeline_stage_ctrl against a rule-level reference model.
module tb_pipeline_stage_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  pipeline_stage_ctrl_if bus ();

  pipeline_stage_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a list of pipeline slots plus two saturating tallies.
  bit          m_valid [4];
  int          m_state;
  longint      m_stall, m_flush;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle(input bit rst, input bit sf, input bit sd, input bit fe,
                          input bit pc, input bit mb, input bit pl = 0,
                          input logic [31:0] plv = 32'h0);
    bit stall, ce, en_front, en_all, c_if, c_ex;
    bit nv [4];
    @(negedge clk);
    reset = rst;
    bus.StallF = sf; bus.StallD = sd; bus.FlushE = fe;
    bus.PCSrcD = pc; bus.MemBusyM = mb;
    bus.PreloadStall = pl; bus.PreloadVal = plv;
    #1;
    stall = (sf || sd) && !mb;
    if (rst) begin
      en_front = 1; en_all = 1; c_if = 1; c_ex = 1;
    end else if (mb) begin
      en_front = 0; en_all = 0; c_if = 0; c_ex = 0;
    end else begin
      en_front = !stall; en_all = 1;
      c_if = pc && !stall;
      c_ex = stall || fe;
    end
    chk("EnPC",    {31'b0, bus.EnPC},    {31'b0, en_front});
    chk("EnIFID",  {31'b0, bus.EnIFID},  {31'b0, en_front});
    chk("EnIDEX",  {31'b0, bus.EnIDEX},  {31'b0, en_all});
    chk("EnEXMEM", {31'b0, bus.EnEXMEM}, {31'b0, en_all});
    chk("EnMEMWB", {31'b0, bus.EnMEMWB}, {31'b0, en_all});
    chk("ClrIFID", {31'b0, bus.ClrIFID}, {31'b0, c_if});
    chk("ClrIDEX", {31'b0, bus.ClrIDEX}, {31'b0, c_ex});
    @(posedge clk);
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_state = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (mb) m_state = 2;
      else if (stall) m_state = 1;
      else if (pc) m_state = 3;
      else m_state = 0;
      if (!mb) begin
        // Slots move one stage older; a cleared slot enters as a bubble.
        nv[3] = m_valid[2];
        nv[2] = m_valid[1];
        nv[1] = c_ex ? 0 : m_valid[0];
        nv[0] = stall ? m_valid[0] : !c_if;
        m_valid = nv;
      end
      if (pl) m_stall = plv;
      else if (mb || stall) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
      if (c_if || c_ex) m_flush = (m_flush + 1 > SAT) ? SAT : m_flush + 1;
    end
    #1;
    chk("State",      {30'b0, bus.State}, m_state);
    chk("ValidD",     {31'b0, bus.ValidD}, {31'b0, m_valid[0]});
    chk("ValidE",     {31'b0, bus.ValidE}, {31'b0, m_valid[1]});
    chk("ValidM",     {31'b0, bus.ValidM}, {31'b0, m_valid[2]});
    chk("ValidW",     {31'b0, bus.ValidW}, {31'b0, m_valid[3]});
    chk("StallCount", bus.StallCount, m_stall[31:0]);
    chk("FlushCount", bus.FlushCount, m_flush[31:0]);
  endtask

  initial begin
    reset = 1;
    bus.StallF = 0; bus.StallD = 0; bus.FlushE = 0; bus.PCSrcD = 0; bus.MemBusyM = 0;
    bus.PreloadStall = 0; bus.PreloadVal = '0;
    foreach (m_valid[i]) m_valid[i] = 0;
    m_state = 0; m_stall = 0; m_flush = 0;

    // Reset, then fill D..W with no hazards.
    repeat (3) do_cycle(1, 0, 0, 0, 0, 0);
    repeat (5) do_cycle(0, 0, 0, 0, 0, 0);
    chk("fill_W", {31'b0, bus.ValidW}, 32'd1);

    // Single-cycle StallD + FlushE.
    do_cycle(0, 0, 1, 1, 0, 0);
    chk("haz_state", {30'b0, bus.State}, 32'd1);
    chk("haz_stallcnt", bus.StallCount, 32'd1);
    chk("haz_flushcnt", bus.FlushCount, 32'd1);
    repeat (3) do_cycle(0, 0, 0, 0, 0, 0);

    // Single-cycle branch redirect.
    do_cycle(0, 0, 0, 0, 1, 0);
    chk("br_state", {30'b0, bus.State}, 32'd3);
    chk("br_validD", {31'b0, bus.ValidD}, 32'd0);
    chk("br_flushcnt", bus.FlushCount, 32'd2);
    repeat (4) do_cycle(0, 0, 0, 0, 0, 0);

    // Memory busy dominates a simultaneous stall and branch.
    repeat (3) do_cycle(0, 0, 1, 0, 1, 1);
    chk("mem_stallcnt", bus.StallCount, 32'd4);
    chk("mem_state", {30'b0, bus.State}, 32'd2);
    do_cycle(0, 0, 0, 0, 0, 0);

    // Stall counter saturation.
    do_cycle(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    repeat (3) do_cycle(0, 1, 0, 0, 0, 0);
    chk("sat_stallcnt", bus.StallCount, 32'hFFFF_FFFF);

    // Reset landing in the middle of MEM_WAIT.
    repeat (2) do_cycle(0, 0, 0, 0, 0, 1);
    do_cycle(1, 0, 0, 0, 0, 1);
    chk("rst_state", {30'b0, bus.State}, 32'd0);
    chk("rst_stallcnt", bus.StallCount, 32'd0);
    chk("rst_validW", {31'b0, bus.ValidW}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 6) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_ctrl.md
PIPELINE_STAGE_CTRL -- requirements
Module: pipeline_stage_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: StallF, StallD, FlushE  in  1 each  hazard requests from the hazard unit.
REQ-004 SHALL have: PCSrcD  in  1  branch in Decode resolved taken.
REQ-005 SHALL have: MemBusyM  in  1  data memory not ready; the Memory-stage access must hold.
REQ-006 SHALL have: EnPC, EnIFID, EnIDEX, EnEXMEM, EnMEMWB  out  1 each  pipeline-register load enables.
REQ-007 SHALL have: ClrIFID, ClrIDEX  out  1 each  synchronous bubble-insert clears for those registers.
REQ-008 SHALL have: ValidD, ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction.
REQ-009 SHALL have: State  out  2  current controller state.
REQ-010 SHALL have: StallCount, FlushCount  out  32 each  performance counters.

Function
REQ-011 SHALL implement states RUN=0, HAZ_STALL=1, MEM_WAIT=2, REDIRECT=3; State SHALL be the registered state.
REQ-012 SHALL evaluate events in the same cycle in priority order: MemBusyM > (StallF|StallD) > PCSrcD > none.
REQ-013 SHALL, on MemBusyM=1: drive all Enx=0 and all Clrx=0, leave all Valid bits unchanged, and take next state MEM_WAIT.
REQ-014 SHALL, on hazard stall without MemBusyM: drive EnPC=0, EnIFID=0, ClrIDEX=1, EnEXMEM=EnMEMWB=1, ValidE<=0, and take next state HAZ_STALL; FlushE SHALL force ClrIDEX=1 independently of StallD.
REQ-015 SHALL, on PCSrcD=1 without stall or MemBusyM: drive all Enx=1, ClrIFID=1, ValidD<=0, and take next state REDIRECT; a PCSrcD asserted during a stall SHALL be ignored until the stall clears.
REQ-016 SHALL, with no event: drive all Enx=1 and Clrx=0, and take next state RUN.
REQ-017 SHALL, whenever a stage advances: ValidD<=1 unless cleared, ValidE<=ValidD, ValidM<=ValidE, ValidW<=ValidM.
REQ-018 SHALL drive all enable/clear outputs combinationally from the current inputs, with zero-cycle latency.
REQ-019 SHALL increment StallCount by 1 in each cycle with MemBusyM or a hazard stall.
REQ-020 SHALL increment FlushCount by 1 in each cycle with ClrIFID=1 or ClrIDEX=1.
REQ-021 SHALL saturate both counters at 0xFFFFFFFF, with no wrap.
REQ-022 SHALL make ClrIFID and ClrIDEX take precedence over their enables in the same cycle.

Reset
REQ-023 SHALL, while reset=1: State=RUN, all Valid bits=0, both counters=0, all Enx=1, all Clrx=1, overriding every input.
REQ-024 SHALL, on reset asserted mid-stall or mid-MEM_WAIT: abandon the operation, with the first cycle after reset in RUN with no pending stall.
REQ-025 SHALL fill the pipeline after reset one Valid bit per cycle: ValidD rises 1 cycle after deassertion and ValidW 4 cycles after.

Structure
REQ-026 SHALL place the state encoding constants and the 32-bit counter width in shared package pipe_ctrl_pkg.
REQ-027 SHALL implement each counter as one instance of sub-module sat_counter (width parameter, inc, clear).
REQ-028 SHALL contain no other sub-modules.

Verification
REQ-029 SHALL cover reset release with no hazards: Valid bits fill D..W over 4 cycles; State=RUN; counters=0.
REQ-030 SHALL cover a single-cycle StallD+FlushE: EnPC=EnIFID=0 and ClrIDEX=1 in that cycle; next cycle ValidE=0 and State=HAZ_STALL; StallCount=1, FlushCount=1.
REQ-031 SHALL cover PCSrcD for 1 cycle: ClrIFID=1 and EnPC=1; next cycle ValidD=0 and State=REDIRECT; FlushCount=1.
REQ-032 SHALL cover MemBusyM for 3 cycles with StallD and PCSrcD also high: all Enx=0 and all Clrx=0 for 3 cycles; Valid bits frozen; StallCount=3.
REQ-033 SHALL cover StallCount preloaded to 0xFFFFFFFE followed by 3 stall cycles: StallCount holds at 0xFFFFFFFF.
REQ-034 SHALL cover reset asserted during MEM_WAIT: next cycle State=RUN, Valid bits=0, counters=0.
